// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the fetch/data memory-port arbiter.
package mem_arb_pkg;

    // Transaction phases of the single-outstanding memory port.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    // Which requester currently owns the memory port.
    typedef enum logic {
        FETCH = 1'b0,
        DATA  = 1'b1
    } owner_t;

    // All-ones byte-enable pattern; sliced down to the actual enable width.
    localparam int BE_MAX_W = 64;
    localparam logic [BE_MAX_W-1:0] BE_ALL = '1;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester-side and memory-side signals of the arbiter, bundled as one bus.
interface mem_port_arbiter_if #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
);
    localparam int BE_W = DATA_WIDTH / 8;

    // Instruction-fetch requester
    logic                     if_req;
    logic [ADDRESS_WIDTH-1:0] if_addr;
    logic                     if_rvalid;
    logic [DATA_WIDTH-1:0]    if_rdata;

    // Load/store requester
    logic                     d_req;
    logic                     d_we;
    logic [ADDRESS_WIDTH-1:0] d_addr;
    logic [DATA_WIDTH-1:0]    d_wdata;
    logic [BE_W-1:0]          d_be;
    logic                     d_rvalid;
    logic [DATA_WIDTH-1:0]    d_rdata;

    // Status back to the CPU
    logic                     err;
    logic                     cpu_stall;

    // External memory port
    logic                     mem_req;
    logic                     mem_we;
    logic [ADDRESS_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0]    mem_wdata;
    logic [BE_W-1:0]          mem_be;
    logic                     mem_gnt;
    logic                     mem_rvalid;
    logic [DATA_WIDTH-1:0]    mem_rdata;

    // Arbiter view
    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be,
               mem_gnt, mem_rvalid, mem_rdata,
        output if_rvalid, if_rdata, d_rvalid, d_rdata, err, cpu_stall,
               mem_req, mem_we, mem_addr, mem_wdata, mem_be
    );

    // Environment view: requesters plus memory
    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be,
               mem_gnt, mem_rvalid, mem_rdata,
        input  if_rvalid, if_rdata, d_rvalid, d_rdata, err, cpu_stall,
               mem_req, mem_we, mem_addr, mem_wdata, mem_be
    );

endinterface

// File: rtl/mem_arb_timer.sv
// Transaction watchdog: counts cycles spent waiting on memory and flags expiry.
module mem_arb_timer #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);
    localparam int CW = $clog2(TIMEOUT_CYCLES);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign expired_o = (cnt_q == CW'(TIMEOUT_CYCLES - 1));

    // Clear wins over count; hold at the expiry value so the count never wraps.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !expired_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store, one
// transaction at a time, alternating priority on contention.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDRESS_WIDTH  = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input logic               clk,
    input logic               rst,
    mem_port_arbiter_if.slave bus
);
    localparam int BE_W = DATA_WIDTH / 8;

    state_t                   state_q, state_d;
    owner_t                   owner_q, owner_d;
    owner_t                   last_owner_q, last_owner_d;
    owner_t                   winner;

    logic                     mem_req_q, mem_req_d;
    logic                     mem_we_q, mem_we_d;
    logic [ADDRESS_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0]    mem_wdata_q, mem_wdata_d;
    logic [BE_W-1:0]          mem_be_q, mem_be_d;

    logic                     if_rvalid_q, if_rvalid_d;
    logic                     d_rvalid_q, d_rvalid_d;
    logic                     err_q, err_d;
    logic [DATA_WIDTH-1:0]    if_rdata_q, if_rdata_d;
    logic [DATA_WIDTH-1:0]    d_rdata_q, d_rdata_d;

    logic                     finish;
    logic                     finish_err;
    logic [DATA_WIDTH-1:0]    finish_data;

    logic                     timer_clr;
    logic                     timer_en;
    logic                     timer_expired;

    mem_arb_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (timer_clr),
        .en_i     (timer_en),
        .expired_o(timer_expired)
    );

    assign timer_en  = (state_q == ISSUE) || (state_q == WAIT);
    assign timer_clr = (state_q == IDLE) && (bus.if_req || bus.d_req);

    // Pick the requester to serve: a sole requester wins, a tie goes to whoever was not served last.
    always_comb begin
        winner = FETCH;
        if (bus.if_req && bus.d_req) begin
            winner = (last_owner_q == FETCH) ? DATA : FETCH;
        end else if (bus.d_req) begin
            winner = DATA;
        end
    end

    // Next-state and next-output logic of the transaction FSM.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_be_d     = mem_be_q;
        if_rvalid_d  = 1'b0;
        d_rvalid_d   = 1'b0;
        err_d        = 1'b0;
        if_rdata_d   = if_rdata_q;
        d_rdata_d    = d_rdata_q;
        finish       = 1'b0;
        finish_err   = 1'b0;
        finish_data  = '0;

        case (state_q)
            IDLE: begin
                if (bus.if_req || bus.d_req) begin
                    owner_d   = winner;
                    mem_req_d = 1'b1;
                    state_d   = ISSUE;
                    if (winner == FETCH) begin
                        mem_we_d    = 1'b0;
                        mem_addr_d  = bus.if_addr;
                        mem_wdata_d = '0;
                        mem_be_d    = BE_ALL[BE_W-1:0];
                    end else begin
                        mem_we_d    = bus.d_we;
                        mem_addr_d  = bus.d_addr;
                        mem_wdata_d = bus.d_wdata;
                        mem_be_d    = bus.d_be;
                    end
                end
            end
            ISSUE: begin
                // A response arriving together with the grant is not a response yet.
                if (timer_expired) begin
                    finish     = 1'b1;
                    finish_err = 1'b1;
                end else if (bus.mem_gnt) begin
                    mem_req_d = 1'b0;
                    state_d   = WAIT;
                end
            end
            WAIT: begin
                // A real response beats a simultaneous timeout.
                if (bus.mem_rvalid) begin
                    finish      = 1'b1;
                    finish_data = bus.mem_rdata;
                end else if (timer_expired) begin
                    finish     = 1'b1;
                    finish_err = 1'b1;
                end
            end
            RESP: begin
                last_owner_d = owner_q;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (finish) begin
            state_d   = RESP;
            mem_req_d = 1'b0;
            err_d     = finish_err;
            if (owner_q == FETCH) begin
                if_rvalid_d = 1'b1;
                if_rdata_d  = finish_data;
            end else begin
                d_rvalid_d = 1'b1;
                d_rdata_d  = finish_data;
            end
        end
    end

    // State and output registers; reset abandons any in-flight transaction.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            owner_q      <= FETCH;
            last_owner_q <= FETCH;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_be_q     <= '0;
            if_rvalid_q  <= 1'b0;
            d_rvalid_q   <= 1'b0;
            err_q        <= 1'b0;
            if_rdata_q   <= '0;
            d_rdata_q    <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_be_q     <= mem_be_d;
            if_rvalid_q  <= if_rvalid_d;
            d_rvalid_q   <= d_rvalid_d;
            err_q        <= err_d;
            if_rdata_q   <= if_rdata_d;
            d_rdata_q    <= d_rdata_d;
        end
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_be    = mem_be_q;
    assign bus.if_rvalid = if_rvalid_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_rvalid  = d_rvalid_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.err       = err_q;
    assign bus.cpu_stall = (bus.if_req & ~if_rvalid_q) | (bus.d_req & ~d_rvalid_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized scoreboard bench for mem_port_arbiter with a reactive memory model.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;
    localparam int T  = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus_if ();

    mem_port_arbiter #(
        .ADDRESS_WIDTH (AW),
        .DATA_WIDTH    (DW),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus_if)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int rv_count = 0;
    int txn_no = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        owner_t          owner;
        logic [DW-1:0]   data;
        logic            err;
        int              cyc;
    } exp_t;

    exp_t exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Requester inputs as they will be sampled on the coming edge.
    logic          snap_if, snap_d, snap_we;
    logic [AW-1:0] snap_iaddr, snap_daddr;
    logic [DW-1:0] snap_wdata;
    logic [BW-1:0] snap_be;

    always @(negedge clk) begin
        snap_if    = bus_if.if_req;
        snap_d     = bus_if.d_req;
        snap_we    = bus_if.d_we;
        snap_iaddr = bus_if.if_addr;
        snap_daddr = bus_if.d_addr;
        snap_wdata = bus_if.d_wdata;
        snap_be    = bus_if.d_be;
    end

    // Reference arbitration state and expected payload of the current transaction.
    owner_t        last_served = FETCH;
    bit            rst_test    = 1'b0;
    logic          pl_we;
    logic [AW-1:0] pl_addr;
    logic [DW-1:0] pl_wdata;
    logic [BW-1:0] pl_be;

    task automatic check_payload();
        check("mem_we",    bus_if.mem_we,    pl_we);
        check("mem_addr",  bus_if.mem_addr,  pl_addr);
        check("mem_wdata", bus_if.mem_wdata, pl_wdata);
        check("mem_be",    bus_if.mem_be,    pl_be);
    endtask

    // Memory side of one transaction, entered right after mem_req is first seen high.
    task automatic serve();
        owner_t        w;
        exp_t          e;
        int            e0, gd, r;
        bit            to_mode, gstall;
        logic [DW-1:0] rdata;
        e0 = cyc;
        if (rst_test) begin
            bus_if.mem_gnt = 1'b1;
            @(posedge clk); #1;
            bus_if.mem_gnt = 1'b0;
            return;
        end
        if (snap_if && snap_d) w = (last_served == FETCH) ? DATA : FETCH;
        else if (snap_d)       w = DATA;
        else                   w = FETCH;
        last_served = w;
        if (w == FETCH) begin
            pl_we = 1'b0; pl_addr = snap_iaddr; pl_wdata = '0; pl_be = '1;
        end else begin
            pl_we = snap_we; pl_addr = snap_daddr; pl_wdata = snap_wdata; pl_be = snap_be;
        end
        check_payload();
        to_mode = ($urandom_range(0, 9) == 0);
        rdata   = $urandom;
        e.owner = w;
        if (!to_mode) begin
            gd = $urandom_range(0, 5);
            r  = $urandom_range(1, 4);
            e.data = rdata; e.err = 1'b0; e.cyc = e0 + gd + 1 + r;
            exp_q.push_back(e);
            repeat (gd) begin
                @(posedge clk); #1;
                check("mem_req_held", bus_if.mem_req, 1);
                check_payload();
            end
            bus_if.mem_gnt = 1'b1;
            if ($urandom_range(0, 3) == 0) begin
                bus_if.mem_rvalid = 1'b1;
                bus_if.mem_rdata  = ~rdata;
            end
            @(posedge clk); #1;
            bus_if.mem_gnt    = 1'b0;
            bus_if.mem_rvalid = 1'b0;
            check("mem_req_drop", bus_if.mem_req, 0);
            repeat (r - 1) begin
                @(posedge clk); #1;
            end
            bus_if.mem_rvalid = 1'b1;
            bus_if.mem_rdata  = rdata;
            @(posedge clk); #1;
            bus_if.mem_rvalid = 1'b0;
            bus_if.mem_rdata  = $urandom;
        end else begin
            gstall = ($urandom_range(0, 1) == 1);
            e.data = '0; e.err = 1'b1; e.cyc = e0 + T;
            exp_q.push_back(e);
            if (gstall) begin
                bus_if.mem_gnt = 1'b1;
                @(posedge clk); #1;
                bus_if.mem_gnt = 1'b0;
            end
            while (cyc < e0 + T) begin
                check("mem_req_pending", bus_if.mem_req, gstall ? 0 : 1);
                @(posedge clk); #1;
            end
            check("mem_req_after_timeout", bus_if.mem_req, 0);
            bus_if.mem_rvalid = 1'b1;
            bus_if.mem_rdata  = $urandom | 32'h1;
            @(posedge clk); #1;
            bus_if.mem_rvalid = 1'b0;
        end
    endtask

    initial begin : memory_model
        bus_if.mem_gnt    = 1'b0;
        bus_if.mem_rvalid = 1'b0;
        bus_if.mem_rdata  = '0;
        forever begin
            @(posedge clk); #1;
            if (rst && bus_if.mem_req) serve();
        end
    end

    // Response monitor: pops the scoreboard whenever an rvalid pulse appears.
    always @(negedge clk) begin : monitor
        exp_t e;
        check("cpu_stall", bus_if.cpu_stall,
              (bus_if.if_req & ~bus_if.if_rvalid) | (bus_if.d_req & ~bus_if.d_rvalid));
        if (bus_if.if_rvalid || bus_if.d_rvalid) begin
            rv_count++;
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_rvalid: actual if_rvalid=%0b d_rvalid=%0b, required none (cycle %0d)",
                         bus_if.if_rvalid, bus_if.d_rvalid, cyc);
            end else begin
                e = exp_q.pop_front();
                txn_no++;
                check("rvalid_cycle", cyc, e.cyc);
                check("if_rvalid", bus_if.if_rvalid, e.owner == FETCH);
                check("d_rvalid",  bus_if.d_rvalid,  e.owner == DATA);
                check("err",       bus_if.err,       e.err);
                check("rdata", (e.owner == FETCH) ? bus_if.if_rdata : bus_if.d_rdata, e.data);
                $display("txn %0d: owner=%s rdata=0x%08h err=%0b cycle=%0d",
                         txn_no, e.owner.name(), e.data, e.err, cyc);
            end
        end else begin
            check("err_idle", bus_if.err, 0);
            if (exp_q.size() > 0 && cyc > exp_q[0].cyc) begin
                checks++; errors++;
                $display("FAIL missing_rvalid: actual none, required pulse at cycle %0d (now %0d)",
                         exp_q[0].cyc, cyc);
                void'(exp_q.pop_front());
            end
        end
    end

    bit run     = 1'b0;
    bit if_busy = 1'b0;
    bit d_busy  = 1'b0;

    initial begin : fetch_requester
        int n, g;
        bus_if.if_req  = 1'b0;
        bus_if.if_addr = '0;
        wait (run);
        @(posedge clk); #2;
        while (run) begin
            bus_if.if_req  = 1'b1;
            bus_if.if_addr = $urandom & 32'hFFFF_FFFC;
            if_busy = 1'b1;
            n = 0;
            do begin @(posedge clk); #2; n++; end while (!bus_if.if_rvalid && n < 200);
            if (!bus_if.if_rvalid) begin
                checks++; errors++;
                $display("FAIL fetch_wait: actual no if_rvalid in %0d cycles, required completion", n);
            end
            if_busy = 1'b0;
            g = $urandom_range(0, 3);
            if (g != 0 || !run) begin
                bus_if.if_req = 1'b0;
                if (run) begin
                    repeat (g) @(posedge clk);
                    #2;
                end
            end
        end
        bus_if.if_req = 1'b0;
    end

    initial begin : data_requester
        int n, g;
        bus_if.d_req   = 1'b0;
        bus_if.d_we    = 1'b0;
        bus_if.d_addr  = '0;
        bus_if.d_wdata = '0;
        bus_if.d_be    = '0;
        wait (run);
        @(posedge clk); #2;
        while (run) begin
            bus_if.d_req   = 1'b1;
            bus_if.d_we    = $urandom_range(0, 1);
            bus_if.d_addr  = $urandom;
            bus_if.d_wdata = $urandom;
            bus_if.d_be    = 4'($urandom_range(1, 15));
            d_busy = 1'b1;
            n = 0;
            do begin @(posedge clk); #2; n++; end while (!bus_if.d_rvalid && n < 200);
            if (!bus_if.d_rvalid) begin
                checks++; errors++;
                $display("FAIL data_wait: actual no d_rvalid in %0d cycles, required completion", n);
            end
            d_busy = 1'b0;
            g = $urandom_range(0, 3);
            if (g != 0 || !run) begin
                bus_if.d_req = 1'b0;
                if (run) begin
                    repeat (g) @(posedge clk);
                    #2;
                end
            end
        end
        bus_if.d_req = 1'b0;
    end

    task automatic summary_and_finish();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_mem_req"},   bus_if.mem_req,   0);
        check({tag, "_mem_we"},    bus_if.mem_we,    0);
        check({tag, "_mem_addr"},  bus_if.mem_addr,  0);
        check({tag, "_mem_wdata"}, bus_if.mem_wdata, 0);
        check({tag, "_mem_be"},    bus_if.mem_be,    0);
        check({tag, "_if_rvalid"}, bus_if.if_rvalid, 0);
        check({tag, "_d_rvalid"},  bus_if.d_rvalid,  0);
        check({tag, "_err"},       bus_if.err,       0);
        check({tag, "_if_rdata"},  bus_if.if_rdata,  0);
        check({tag, "_d_rdata"},   bus_if.d_rdata,   0);
        check({tag, "_cpu_stall"}, bus_if.cpu_stall, 0);
    endtask

    initial begin : main
        int n, rv_before;
        bit saw;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        #1 rst = 1'b1;

        // Random traffic from both requesters.
        run = 1'b1;
        repeat (800) @(posedge clk);
        run = 1'b0;
        n = 0;
        do begin @(posedge clk); #2; n++; end
        while ((if_busy || d_busy || exp_q.size() != 0 || bus_if.if_req || bus_if.d_req) && n < 200);
        check("drain_done", (if_busy || d_busy || exp_q.size() != 0) ? 1 : 0, 0);
        repeat (3) @(posedge clk);
        #2;

        // Reset while a fetch is waiting for its response; the late response must be ignored.
        rst_test = 1'b1;
        bus_if.if_req  = 1'b1;
        bus_if.if_addr = 32'h0000_0040;
        saw = 1'b0;
        n = 0;
        do begin
            @(posedge clk); #2; n++;
            if (bus_if.mem_req) saw = 1'b1;
        end while (!(saw && !bus_if.mem_req) && n < 20);
        check("reached_wait", (saw && !bus_if.mem_req) ? 1 : 0, 1);
        rst = 1'b0;
        bus_if.if_req = 1'b0;
        last_served = FETCH;
        rv_before = rv_count;
        @(posedge clk); #1;
        check_reset_outputs("midwait_reset");
        #1;
        rst = 1'b1;
        bus_if.mem_rvalid = 1'b1;
        bus_if.mem_rdata  = 32'hBAD0_0BAD;
        @(posedge clk); #2;
        bus_if.mem_rvalid = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        check("stray_after_reset_rvalids", rv_count - rv_before, 0);
        rst_test = 1'b0;

        // Contention straight after reset: data goes first, then the fetch.
        bus_if.if_req  = 1'b1;
        bus_if.if_addr = 32'h0000_0010;
        bus_if.d_req   = 1'b1;
        bus_if.d_we    = 1'b1;
        bus_if.d_addr  = 32'h0000_0100;
        bus_if.d_wdata = 32'hDEAD_BEEF;
        bus_if.d_be    = 4'hF;
        n = 0;
        do begin @(posedge clk); #2; n++; end while (!bus_if.d_rvalid && n < 100);
        check("contention_first_is_data", bus_if.d_rvalid, 1);
        check("contention_fetch_waits", bus_if.if_rvalid, 0);
        bus_if.d_req = 1'b0;
        n = 0;
        do begin @(posedge clk); #2; n++; end while (!bus_if.if_rvalid && n < 100);
        check("contention_second_is_fetch", bus_if.if_rvalid, 1);
        bus_if.if_req = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        check("scoreboard_empty", exp_q.size(), 0);
        summary_and_finish();
    end

    initial begin : watchdog
        #200000;
        checks++; errors++;
        $display("FAIL watchdog: actual simulation still running at %0t, required completion", $time);
        summary_and_finish();
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one unified memory port between the CPU's instruction-fetch requester and its load/store requester.
- Uses a registered, single-outstanding-transaction FSM with alternating priority on contention and a response timeout.
- Sits between the PC/instruction path and the data-memory path on one side, and the external memory on the other.
- Drives cpu_stall to freeze the PC register while either requester is unserved.

Parameters:
- ADDRESS_WIDTH, 32: memory byte-address width.
- DATA_WIDTH, 32: memory data width; byte enables are DATA_WIDTH/8 bits wide.
- TIMEOUT_CYCLES, 16: maximum cycles in ISSUE plus WAIT before the transaction is aborted; must be at least 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-low reset.
- if_req  in  1  fetch request; held with if_addr until if_rvalid.
- if_addr  in  ADDRESS_WIDTH  fetch address.
- if_rvalid  out  1  one-cycle pulse: fetch complete.
- if_rdata  out  DATA_WIDTH  instruction word; valid with if_rvalid.
- d_req  in  1  load/store request; held with payload until d_rvalid.
- d_we  in  1  1 = store.
- d_addr  in  ADDRESS_WIDTH  data address.
- d_wdata  in  DATA_WIDTH  store data.
- d_be  in  DATA_WIDTH/8  store byte enables.
- d_rvalid  out  1  one-cycle pulse: data access complete (load or store).
- d_rdata  out  DATA_WIDTH  load data; valid with d_rvalid.
- err  out  1  high with the rvalid pulse when the transaction timed out.
- cpu_stall  out  1  combinational: (if_req & ~if_rvalid) | (d_req & ~d_rvalid).
- mem_req  out  1  registered; held until mem_gnt is sampled high.
- mem_we, mem_addr, mem_wdata, mem_be  out  1/ADDRESS_WIDTH/DATA_WIDTH/DATA_WIDTH/8  registered payload, stable while mem_req is high.
- mem_gnt  in  1  memory accepts the request this cycle.
- mem_rvalid  in  1  memory response (read data or write acknowledge).
- mem_rdata  in  DATA_WIDTH  read data.

Behaviour:
- States:
  - IDLE: if any req is high, latch owner and payload, go to ISSUE.
  - ISSUE: mem_req=1; on mem_gnt go to WAIT.
  - WAIT: mem_req=0; on mem_rvalid capture mem_rdata, go to RESP.
  - RESP: pulse the owner's rvalid for exactly one cycle, update last_owner, go to IDLE.
- Arbitration:
  - Sole requester wins.
  - If both requesters are high in IDLE, the winner is the owner opposite last_owner.
  - last_owner resets to FETCH, so data wins the first contention; contention then alternates.
- Payload:
  - Fetch is latched as mem_we=0, mem_be=all ones, mem_wdata=0.
  - Data is latched from d_*.
  - Requester inputs are ignored after latching.
- Latency: a request sampled in IDLE at cycle N gives mem_req at N+1. With mem_gnt at N+1 and mem_rvalid at N+2, rvalid is at N+3. Minimum 3 cycles; back-to-back transactions take 4 cycles each.
- Requester rule: drop or replace req on the edge after the rvalid pulse. A req still high in the following IDLE cycle is treated as a new request.
- Timeout:
  - A counter clears on IDLE->ISSUE and increments every cycle in ISSUE or WAIT.
  - On reaching TIMEOUT_CYCLES-1 with no mem_rvalid: drop mem_req, go to RESP with err=1 and rdata=0.
  - mem_rvalid and timeout in the same cycle: the response wins, err=0.
- Stray responses: mem_rvalid outside WAIT is ignored. This includes a late response after a timeout.
- mem_gnt and mem_rvalid in the same ISSUE cycle: treat as granted only; the response is expected in WAIT.
- Reset: rst=0 on an edge forces IDLE, mem_req=0, all payload registers 0, if_rvalid=d_rvalid=err=0, rdata outputs 0, counter 0, last_owner=FETCH. This applies mid-transaction; the in-flight response is discarded as stray.

Decomposition:
- Package mem_arb_pkg:
  - state_t enum {IDLE, ISSUE, WAIT, RESP}.
  - owner_t enum {FETCH, DATA}.
  - Constant BE_ALL.
- One sub-module, mem_arb_timer: clear/enable inputs, expired output, parameterised by TIMEOUT_CYCLES.

Test Plan:
- Fetch only: if_req=1, if_addr=0x0000_0010. Memory grants at once and returns 0x0000_0513 the next cycle -> if_rvalid at cycle 3 with if_rdata=0x0000_0513, mem_we=0, err=0, cpu_stall high in cycles 0-2.
- Store: d_req=1, d_we=1, d_addr=0x100, d_wdata=0xDEADBEEF, d_be=0xF -> identical values appear on the mem_* payload while mem_req is high; d_rvalid pulses once on the ack.
- Contention: both requests raised at cycle 0 and held, re-raising after each completion -> service order DATA, FETCH, DATA, with no requester served twice in a row.
- Grant delay: mem_gnt withheld 5 cycles -> mem_req and payload stay stable for 6 cycles; rvalid is delayed by exactly 5 cycles.
- Timeout: no mem_gnt, TIMEOUT_CYCLES=16 -> rvalid with err=1 and rdata=0; a later mem_rvalid is ignored.
- Reset mid-WAIT: rst=0 for 1 cycle -> all outputs 0 next cycle; the subsequent mem_rvalid produces no rvalid pulse.
